// File: rtl/uart_packet_tx.sv
// uart_packet_tx
//   Multi-word UART transmitter. A packet of PACKET_WIDTH words is captured
//   over a valid/ready handshake in IDLE and sent word by word, LSB first,
//   as start / data / [parity] / stop frames. An optional run of idle (mark)
//   bit-times follows each packet. One bit-time per clk_baud cycle.
//
//   Optional feature macro: UART_TX_PARITY_EN
//     defined   -> a parity bit (^word ^ PARITY_ODD) follows the data bits
//     undefined -> no parity bit, PARITY_ODD has no effect
//
// Ports
//   clk_baud      in   bit-rate clock
//   rst           in   asynchronous, active-high reset
//   sys_packet    in   packet, word 0 in bits [DATA_BITS-1:0]
//   packet_valid  in   sys_packet holds a packet to send
//   packet_ready  out  block can accept a packet (IDLE only)
//   uart_stream   out  registered serial line, idle high
//   busy          out  high from capture until return to IDLE
//   word_index    out  index of the word being sent
//
// state    | meaning
// ---------+--------------------------------------------------
// S_IDLE   | line mark, ready for a packet
// S_START  | start bit (0); loads the current word for shifting
// S_DATA   | DATA_BITS data bits, LSB first
// S_PARITY | parity bit (only reachable with UART_TX_PARITY_EN)
// S_STOP   | STOP_BITS stop bits (1); then next word, GAP or IDLE
// S_GAP    | IDLE_GAP extra mark bit-times after the packet
module uart_packet_tx #(
  parameter int PACKET_WIDTH = 4,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0,
  parameter int IDLE_GAP     = 0,
  localparam int IW = (PACKET_WIDTH > 1) ? $clog2(PACKET_WIDTH) : 1
) (
  input  logic                               clk_baud,
  input  logic                               rst,
  input  logic [PACKET_WIDTH*DATA_BITS-1:0]  sys_packet,
  input  logic                               packet_valid,
  output logic                               packet_ready,
  output logic                               uart_stream,
  output logic                               busy,
  output logic [IW-1:0]                      word_index
);

  localparam int PKT_W = PACKET_WIDTH * DATA_BITS;
  // Shared bit counter covers DATA_BITS-1 and STOP_BITS-1.
  localparam int BW = $clog2(DATA_BITS + 1);
  // Gap counter holds up to 255.
  localparam int GW = 8;

  localparam logic [BW-1:0] DB_LAST  = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] SB_LAST  = BW'(STOP_BITS - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((IDLE_GAP > 0) ? IDLE_GAP - 1 : 0);
  localparam logic [IW-1:0] IDX_LAST = IW'(PACKET_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_GAP
  } state_t;

  state_t                 state_q, state_d;
  logic [PKT_W-1:0]       pkt_q, pkt_d;
  logic [IW-1:0]          word_idx_q, word_idx_d;
  logic [DATA_BITS-1:0]   shreg_q, shreg_d;
  logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
  logic [GW-1:0]          gap_cnt_q, gap_cnt_d;
  logic                   line_q, line_d;
  logic                   ready_q, ready_d;
  logic                   busy_q, busy_d;

  logic [DATA_BITS-1:0]   cur_word;
  logic                   parity_bit;

  always_comb begin
    cur_word = '0;
    for (int i = 0; i < PACKET_WIDTH; i++) begin
      if (word_idx_q == IW'(i)) cur_word = pkt_q[i*DATA_BITS +: DATA_BITS];
    end
    parity_bit = (^cur_word) ^ (PARITY_ODD != 0);
  end

  always_comb begin
    state_d    = state_q;
    pkt_d      = pkt_q;
    word_idx_d = word_idx_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    gap_cnt_d  = gap_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (packet_valid && ready_q) begin
          pkt_d      = sys_packet;
          word_idx_d = '0;
          state_d    = S_START;
        end
      end
      S_START: begin
        shreg_d   = cur_word;
        bit_cnt_d = DB_LAST;
        state_d   = S_DATA;
      end
      S_DATA: begin
        shreg_d = shreg_q >> 1;
        if (bit_cnt_q == '0) begin
`ifdef UART_TX_PARITY_EN
          state_d   = S_PARITY;
`else
          state_d   = S_STOP;
          bit_cnt_d = SB_LAST;
`endif
        end else begin
          bit_cnt_d = bit_cnt_q - BW'(1);
        end
      end
      S_PARITY: begin
        state_d   = S_STOP;
        bit_cnt_d = SB_LAST;
      end
      S_STOP: begin
        if (bit_cnt_q != '0) begin
          bit_cnt_d = bit_cnt_q - BW'(1);
        end else if (word_idx_q != IDX_LAST) begin
          word_idx_d = word_idx_q + IW'(1);
          state_d    = S_START;
        end else if (IDLE_GAP > 0) begin
          gap_cnt_d = GAP_LAST;
          state_d   = S_GAP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_GAP: begin
        if (gap_cnt_q == '0) state_d = S_IDLE;
        else                 gap_cnt_d = gap_cnt_q - GW'(1);
      end
      default: state_d = S_IDLE;
    endcase

    // The line follows the state one cycle later, so it never depends
    // combinationally on the inputs.
    case (state_q)
      S_START:  line_d = 1'b0;
      S_DATA:   line_d = shreg_q[0];
      S_PARITY: line_d = parity_bit;
      default:  line_d = 1'b1;
    endcase

    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_baud or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pkt_q      <= '0;
      word_idx_q <= '0;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      gap_cnt_q  <= '0;
      line_q     <= 1'b1;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pkt_q      <= pkt_d;
      word_idx_q <= word_idx_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      line_q     <= line_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
    end
  end

  assign packet_ready = ready_q;
  assign uart_stream  = line_q;
  assign busy         = busy_q;
  assign word_index   = word_idx_q;

endmodule
